unified_mem_arbiter: RTL and testbench
======================================

Name: unified_mem_arbiter

Overview:
- Shares the single external memory bus between the pipeline's instruction-fetch port and data port.
- Sits between the execution core and the external mem_* interface, as the first step toward the unified cached bus.
- Registers each request, arbitrates with round-robin fairness, runs one external transaction at a time, and returns read data plus a one-cycle completion pulse to the winning requester.

Parameters:
- ADDR_W, 64, address width of both requesters and the external bus.
- DATA_W, 64, data width of both requesters and the external bus.
- TIMEOUT_CYCLES, 256, watchdog limit in clk cycles; used only when the optional feature is compiled in.

Ports:
- clk  in  1  CPU clock.
- rst_n  in  1  asynchronous active-low reset.
- i_req  in  1  instruction fetch request; held until i_ack.
- i_addr  in  ADDR_W  fetch address; stable while i_req is high.
- i_rdata  out  DATA_W  fetch data; valid in the i_ack cycle.
- i_ack  out  1  one-cycle completion pulse for a fetch.
- d_req  in  1  data request; held until d_ack.
- d_we  in  1  1 = write, 0 = read.
- d_width  in  2  access width code, passed through unchanged.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  write data.
- d_rdata  out  DATA_W  read data; valid in the d_ack cycle.
- d_ack  out  1  one-cycle completion pulse for a data access.
- mem_addr  out  ADDR_W  external address.
- mem_dout  out  DATA_W  external write data.
- mem_width  out  2  external access width.
- mem_addr_valid  out  1  external transaction active.
- mem_dout_write  out  1  external write qualifier.
- mem_din  in  DATA_W  external read data.
- mem_din_ready  in  1  external completion strobe.
- busy  out  1  high whenever the state is not IDLE.
- err  out  1  timeout flag (optional feature only).

Behaviour:
- Reset (asynchronous, rst_n low):
  - state = IDLE, last_grant = I (so D wins the first tie).
  - All outputs 0: i_ack, d_ack, mem_addr_valid, mem_dout_write, busy, err, mem_addr, mem_dout, mem_width, i_rdata, d_rdata.
- FSM states: IDLE, GRANT_I, GRANT_D, RESP.
- IDLE:
  - Only i_req: go to GRANT_I.
  - Only d_req: go to GRANT_D.
  - Both high: grant the requester that is not last_grant (round-robin), then update last_grant.
  - On the transition, latch addr/wdata/we/width into the mem_* output registers.
  - mem_addr_valid goes high the cycle after a request is seen, so request-to-bus latency is 1 cycle.
- GRANT_x:
  - Hold mem_addr_valid = 1 and all latched outputs stable.
  - mem_dout_write = d_we in GRANT_D; always 0 in GRANT_I.
  - Wait for mem_din_ready. In its cycle, capture mem_din into the winner's rdata register, drop mem_addr_valid and mem_dout_write, and go to RESP.
  - Write transactions still wait for mem_din_ready.
- RESP:
  - Pulse the winner's ack for exactly 1 cycle, then go to IDLE.
  - A requester holding req through its ack is not re-granted in that same cycle.
  - The winner's rdata holds its value until that requester's next ack.
- Minimum turnaround: 3 cycles, from req seen to ack (IDLE→GRANT→RESP with mem_din_ready in the first GRANT cycle). There is no back-to-back overlap.
- Requester changes:
  - A request dropped before grant is ignored; no ack is produced.
  - A request dropped after grant still completes on the bus; the ack is still pulsed and is ignored by the requester.
- mem_din_ready outside GRANT_x is ignored.
- Simultaneous new request and RESP: the new request is arbitrated in the following IDLE cycle.
- Reset mid-transaction returns to the reset values immediately; no ack is generated for the in-flight access.

Optional Feature:
- Macro: UNIFIED_MEM_ARBITER_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to GRANT_x and increments each GRANT cycle.
  - On reaching TIMEOUT_CYCLES without mem_din_ready: abort, go to RESP, ack the winner with rdata = all ones, and set err sticky.
  - err clears only on reset.
- Undefined: no counter, err is tied to 0, and GRANT_x waits indefinitely.

Test Plan:
- Single fetch: i_req=1, i_addr=0x40, mem_din_ready one cycle after valid with mem_din=0xDEADBEEF → mem_addr=0x40, mem_dout_write=0, i_ack pulses once with i_rdata=0xDEADBEEF, busy falls next cycle.
- Data write: d_req=1, d_we=1, d_width=2'b11, d_addr=0x80, d_wdata=0x1234 → mem_dout_write=1 and mem_dout=0x1234 until ready, then d_ack for 1 cycle.
- Simultaneous i_req and d_req from reset → D served first, I second; held requests then alternate D,I,D,I over 4 transactions.
- Stalled bus: hold mem_din_ready=0 for 20 cycles → mem_addr_valid and mem_addr stable, no ack; ready on cycle 21 → ack and data correct.
- Reset asserted while GRANT_D is waiting → all outputs 0 immediately, no d_ack; a new request after reset completes normally.
- With UNIFIED_MEM_ARBITER_TIMEOUT_EN and TIMEOUT_CYCLES=8, never assert ready → i_ack after 8 grant cycles, i_rdata=all ones, err=1 and stays 1.

Source files
------------

// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter
// Shares one external memory bus between the instruction-fetch port (i_*)
// and the data port (d_*). Each request is registered, arbitrated
// round-robin, and run as one external transaction at a time. Read data and
// a one-cycle ack go back to the requester that won.
//
// Optional feature: define UNIFIED_MEM_ARBITER_TIMEOUT_EN to add a grant
// watchdog. After TIMEOUT_CYCLES grant cycles without mem_din_ready, the
// transaction is aborted, the winner is acked with all-ones data and the
// sticky err flag is set. Without the macro, err is tied to 0 and a grant
// waits indefinitely.
//
// Ports:
//   clk, rst_n                         clock, async active-low reset
//   i_req/i_addr -> i_rdata/i_ack      fetch requester
//   d_req/d_we/d_width/d_addr/d_wdata  data requester
//   -> d_rdata/d_ack
//   mem_addr/mem_dout/mem_width/       external bus request side
//   mem_addr_valid/mem_dout_write
//   mem_din/mem_din_ready              external bus response side
//   busy                               FSM not in IDLE
//   err                                sticky timeout flag
module unified_mem_arbiter #(
    parameter int ADDR_W         = 64,
    parameter int DATA_W         = 64,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_ack,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [1:0]        d_width,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ack,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_dout,
    output logic [1:0]        mem_width,
    output logic              mem_addr_valid,
    output logic              mem_dout_write,
    input  logic [DATA_W-1:0] mem_din,
    input  logic              mem_din_ready,
    output logic              busy,
    output logic              err
);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        GRANT_I = 2'b01,
        GRANT_D = 2'b10,
        RESP    = 2'b11
    } state_t;

    state_t state_r, state_s;

    logic last_d_r, last_d_s;     // 1 = last grant went to D
    logic grant_d_r, grant_d_s;   // 1 = current winner is D
    logic load_s;                 // latch a new request onto the bus
    logic done_s;                 // bus completed this cycle
    logic abort_s;                // watchdog expired this cycle
    logic timeout_hit_s;

    logic [ADDR_W-1:0] mem_addr_r;
    logic [DATA_W-1:0] mem_dout_r;
    logic [1:0]        mem_width_r;
    logic              mem_addr_valid_r;
    logic              mem_dout_write_r;
    logic [DATA_W-1:0] i_rdata_r;
    logic [DATA_W-1:0] d_rdata_r;
    logic              i_ack_r;
    logic              d_ack_r;
    logic              busy_r;

    // State, winner and round-robin history registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            last_d_r  <= 1'b0;
            grant_d_r <= 1'b0;
        end else begin
            state_r   <= state_s;
            last_d_r  <= last_d_s;
            grant_d_r <= grant_d_s;
        end
    end

    // Next-state, arbitration and transaction-event decode.
    always_comb begin
        state_s   = state_r;
        last_d_s  = last_d_r;
        grant_d_s = grant_d_r;
        load_s    = 1'b0;
        done_s    = 1'b0;
        abort_s   = 1'b0;
        case (state_r)
            IDLE: begin
                // D wins when alone, or on a tie when I was served last.
                if (d_req && (!i_req || !last_d_r)) begin
                    state_s   = GRANT_D;
                    grant_d_s = 1'b1;
                    last_d_s  = 1'b1;
                    load_s    = 1'b1;
                end else if (i_req) begin
                    state_s   = GRANT_I;
                    grant_d_s = 1'b0;
                    last_d_s  = 1'b0;
                    load_s    = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end
            GRANT_I, GRANT_D: begin
                if (mem_din_ready) begin
                    done_s  = 1'b1;
                    state_s = RESP;
                end else if (timeout_hit_s) begin
                    abort_s = 1'b1;
                    state_s = RESP;
                end else begin
                    state_s = state_r;
                end
            end
            RESP: begin
                // Always pass through IDLE so a held request is re-arbitrated.
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Bus request registers, read-data capture and ack pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_addr_r       <= {ADDR_W{1'b0}};
            mem_dout_r       <= {DATA_W{1'b0}};
            mem_width_r      <= 2'b00;
            mem_addr_valid_r <= 1'b0;
            mem_dout_write_r <= 1'b0;
            i_rdata_r        <= {DATA_W{1'b0}};
            d_rdata_r        <= {DATA_W{1'b0}};
            i_ack_r          <= 1'b0;
            d_ack_r          <= 1'b0;
            busy_r           <= 1'b0;
        end else begin
            busy_r  <= (state_s != IDLE);
            i_ack_r <= (done_s | abort_s) & ~grant_d_r;
            d_ack_r <= (done_s | abort_s) & grant_d_r;
            if (load_s) begin
                mem_addr_r       <= grant_d_s ? d_addr : i_addr;
                mem_dout_r       <= grant_d_s ? d_wdata : {DATA_W{1'b0}};
                // Fetches are always full-width.
                mem_width_r      <= grant_d_s ? d_width : 2'b11;
                mem_addr_valid_r <= 1'b1;
                mem_dout_write_r <= grant_d_s & d_we;
            end else if (done_s | abort_s) begin
                mem_addr_valid_r <= 1'b0;
                mem_dout_write_r <= 1'b0;
                if (grant_d_r) begin
                    d_rdata_r <= abort_s ? {DATA_W{1'b1}} : mem_din;
                end else begin
                    i_rdata_r <= abort_s ? {DATA_W{1'b1}} : mem_din;
                end
            end
        end
    end

`ifdef UNIFIED_MEM_ARBITER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_r;
    logic             err_r;

    // Grant-cycle counter; cnt_r holds (grant cycle number - 1).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (load_s) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if ((state_r == GRANT_I) || (state_r == GRANT_D)) begin
            cnt_r <= cnt_r + CNT_W'(1'b1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign timeout_hit_s = (cnt_r == CNT_W'(TIMEOUT_CYCLES - 1));

    // Sticky timeout flag, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_r <= 1'b0;
        end else if (abort_s) begin
            err_r <= 1'b1;
        end else begin
            err_r <= err_r;
        end
    end

    assign err = err_r;
`else
    assign timeout_hit_s = 1'b0;
    assign err           = 1'b0;
`endif

    assign mem_addr       = mem_addr_r;
    assign mem_dout       = mem_dout_r;
    assign mem_width      = mem_width_r;
    assign mem_addr_valid = mem_addr_valid_r;
    assign mem_dout_write = mem_dout_write_r;
    assign i_rdata        = i_rdata_r;
    assign d_rdata        = d_rdata_r;
    assign i_ack          = i_ack_r;
    assign d_ack          = d_ack_r;
    assign busy           = busy_r;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Self-checking bench for unified_mem_arbiter. Expected acks (side + data)
// are queued when a request is driven and popped when an ack appears.
module tb_unified_mem_arbiter;

    localparam int AW = 64;
    localparam int DW = 64;
`ifdef UNIFIED_MEM_ARBITER_TIMEOUT_EN
    localparam int STALL = 5;
`else
    localparam int STALL = 20;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          i_req = 1'b0;
    logic [AW-1:0] i_addr = '0;
    logic [DW-1:0] i_rdata;
    logic          i_ack;
    logic          d_req = 1'b0;
    logic          d_we = 1'b0;
    logic [1:0]    d_width = 2'b00;
    logic [AW-1:0] d_addr = '0;
    logic [DW-1:0] d_wdata = '0;
    logic [DW-1:0] d_rdata;
    logic          d_ack;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_dout;
    logic [1:0]    mem_width;
    logic          mem_addr_valid;
    logic          mem_dout_write;
    logic [DW-1:0] mem_din = '0;
    logic          mem_din_ready = 1'b0;
    logic          busy;
    logic          err;

    typedef struct packed {
        logic          is_d;
        logic [DW-1:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   d_ack_seen = 0;

    always #5 clk = ~clk;

    unified_mem_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(8)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
        .d_req(d_req), .d_we(d_we), .d_width(d_width), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_rdata(d_rdata), .d_ack(d_ack),
        .mem_addr(mem_addr), .mem_dout(mem_dout), .mem_width(mem_width),
        .mem_addr_valid(mem_addr_valid), .mem_dout_write(mem_dout_write),
        .mem_din(mem_din), .mem_din_ready(mem_din_ready),
        .busy(busy), .err(err)
    );

    always @(posedge clk) begin
        if (d_ack) d_ack_seen <= d_ack_seen + 1;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic exp_t pop_exp();
        exp_t e;
        if (exp_q.size() == 0) e = {1'bx, {DW{1'bx}}};
        else e = exp_q.pop_front();
        return e;
    endfunction

    // Assumes a GRANT cycle: stall, then one ready cycle; returns in RESP.
    task automatic bus_respond(input int stall, input logic [DW-1:0] din);
        mem_din_ready = 1'b0;
        repeat (stall) tick();
        mem_din_ready = 1'b1;
        mem_din = din;
        tick();
        mem_din_ready = 1'b0;
        mem_din = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        logic [DW-1:0] zero_data;
        zero_data = '0;
        #2;
        rst_n = 1'b0;
        #2;
        n_tests++;
        if ({i_ack, d_ack, mem_addr_valid, mem_dout_write, busy, err, mem_width} !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b, required 00000000",
                     {i_ack, d_ack, mem_addr_valid, mem_dout_write, busy, err, mem_width});
        end
        n_tests++;
        if ((mem_addr | mem_dout | i_rdata | d_rdata) !== zero_data) begin
            n_fail++;
            $display("FAIL reset_data: addr=%h dout=%h ird=%h drd=%h, required all 0",
                     mem_addr, mem_dout, i_rdata, d_rdata);
        end
        tick();
        rst_n = 1'b1;
        mem_din_ready = 1'b1;   // stray ready in IDLE must be ignored
        tick();
        tick();
        mem_din_ready = 1'b0;
        n_tests++;
        if ({busy, i_ack, d_ack, mem_addr_valid} !== 4'b0000) begin
            n_fail++;
            $display("FAIL idle_ready_ignored: busy/iack/dack/valid=%b, required 0000",
                     {busy, i_ack, d_ack, mem_addr_valid});
        end
    endtask

    task automatic test_single_fetch();
        exp_t e;
        i_req = 1'b1;
        i_addr = 64'h40;
        exp_q.push_back({1'b0, 64'hDEADBEEF});
        tick();
        n_tests++;
        if ({mem_addr_valid, mem_dout_write, busy} !== 3'b101 || mem_addr !== 64'h40) begin
            n_fail++;
            $display("FAIL fetch_issue: valid/wr/busy=%b addr=%h, required 101 addr=40",
                     {mem_addr_valid, mem_dout_write, busy}, mem_addr);
        end
        bus_respond(1, 64'hDEADBEEF);
        e = pop_exp();
        n_tests++;
        if ({i_ack, d_ack} !== {~e.is_d, e.is_d} || i_rdata !== e.data) begin
            n_fail++;
            $display("FAIL fetch_ack: i/d ack=%b%b rdata=%h, required %b%b %h",
                     i_ack, d_ack, i_rdata, ~e.is_d, e.is_d, e.data);
        end
        i_req = 1'b0;
        tick();
        n_tests++;
        if ({i_ack, busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL fetch_end: ack/busy=%b, required 00", {i_ack, busy});
        end
    endtask

    task automatic test_data_write();
        exp_t e;
        d_req = 1'b1; d_we = 1'b1; d_width = 2'b11;
        d_addr = 64'h80; d_wdata = 64'h1234;
        exp_q.push_back({1'b1, 64'h55AA});
        tick();
        n_tests++;
        if ({mem_addr_valid, mem_dout_write, mem_width} !== 4'b1111 ||
            mem_dout !== 64'h1234 || mem_addr !== 64'h80) begin
            n_fail++;
            $display("FAIL write_issue: valid/wr/width=%b dout=%h addr=%h, required 1111 1234 80",
                     {mem_addr_valid, mem_dout_write, mem_width}, mem_dout, mem_addr);
        end
        bus_respond(3, 64'h55AA);
        e = pop_exp();
        n_tests++;
        if ({i_ack, d_ack} !== {~e.is_d, e.is_d} || d_rdata !== e.data) begin
            n_fail++;
            $display("FAIL write_ack: i/d ack=%b%b rdata=%h, required %b%b %h",
                     i_ack, d_ack, d_rdata, ~e.is_d, e.is_d, e.data);
        end
        n_tests++;
        if ({mem_addr_valid, mem_dout_write} !== 2'b00) begin
            n_fail++;
            $display("FAIL write_release: valid/wr=%b, required 00", {mem_addr_valid, mem_dout_write});
        end
        d_req = 1'b0; d_we = 1'b0;
        tick();
        n_tests++;
        if (d_ack !== 1'b0) begin
            n_fail++;
            $display("FAIL write_ack_pulse: d_ack=%b, required 0", d_ack);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        logic [DW-1:0] din;
        do_reset();
        i_req = 1'b1; i_addr = 64'h100;
        d_req = 1'b1; d_addr = 64'h200; d_we = 1'b0;
        for (int k = 0; k < 4; k++) begin
            exp_q.push_back({(k % 2 == 0), 64'hA000 + 64'(k)});
        end
        for (int k = 0; k < 4; k++) begin
            int w;
            tick();
            n_tests++;
            if (k > 0 && mem_addr_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL rr_no_regrant_%0d: valid=%b, required 0", k, mem_addr_valid);
            end
            w = 0;
            while (mem_addr_valid !== 1'b1 && w < 4) begin
                tick();
                w++;
            end
            n_tests++;
            if (mem_addr_valid !== 1'b1 || mem_addr !== (exp_q[0].is_d ? 64'h200 : 64'h100)) begin
                n_fail++;
                $display("FAIL rr_grant_%0d: valid=%b addr=%h, required valid with addr of side %b",
                         k, mem_addr_valid, mem_addr, exp_q[0].is_d);
            end
            din = 64'hA000 + 64'(k);
            bus_respond(0, din);
            e = pop_exp();
            n_tests++;
            if ({i_ack, d_ack} !== {~e.is_d, e.is_d} || (e.is_d ? d_rdata : i_rdata) !== e.data) begin
                n_fail++;
                $display("FAIL rr_ack_%0d: i/d ack=%b%b ird=%h drd=%h, required %b%b data %h",
                         k, i_ack, d_ack, i_rdata, d_rdata, ~e.is_d, e.is_d, e.data);
            end
        end
        i_req = 1'b0;
        d_req = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_stall();
        exp_t e;
        logic stable_ok;
        i_req = 1'b1;
        i_addr = 64'h1000;
        exp_q.push_back({1'b0, 64'hCAFEF00D12345678});
        tick();
        stable_ok = 1'b1;
        mem_din_ready = 1'b0;
        for (int c = 0; c < STALL; c++) begin
            if (mem_addr_valid !== 1'b1 || mem_addr !== 64'h1000 || i_ack !== 1'b0 || d_ack !== 1'b0)
                stable_ok = 1'b0;
            tick();
        end
        n_tests++;
        if (stable_ok !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_stable: bus not stable or early ack, required stable for %0d cycles", STALL);
        end
        bus_respond(0, 64'hCAFEF00D12345678);
        e = pop_exp();
        n_tests++;
        if ({i_ack, d_ack} !== {~e.is_d, e.is_d} || i_rdata !== e.data) begin
            n_fail++;
            $display("FAIL stall_ack: i/d ack=%b%b rdata=%h, required %b%b %h",
                     i_ack, d_ack, i_rdata, ~e.is_d, e.is_d, e.data);
        end
        i_req = 1'b0;
        tick();
`ifndef UNIFIED_MEM_ARBITER_TIMEOUT_EN
        n_tests++;
        if (err !== 1'b0) begin
            n_fail++;
            $display("FAIL err_tied: err=%b, required 0", err);
        end
`endif
    endtask

    task automatic test_reset_mid();
        exp_t e;
        int base;
        d_req = 1'b1; d_we = 1'b0; d_addr = 64'h300;
        tick();
        tick();
        tick();
        base = d_ack_seen;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({i_ack, d_ack, mem_addr_valid, mem_dout_write, busy, err} !== 6'b000000 ||
            mem_addr !== 64'h0) begin
            n_fail++;
            $display("FAIL reset_mid_outputs: ctrl=%b addr=%h, required 000000 addr=0",
                     {i_ack, d_ack, mem_addr_valid, mem_dout_write, busy, err}, mem_addr);
        end
        d_req = 1'b0;
        mem_din_ready = 1'b1;
        tick();
        tick();
        rst_n = 1'b1;
        mem_din_ready = 1'b0;
        tick();
        tick();
        n_tests++;
        if (d_ack_seen !== base || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_noack: acks=%0d busy=%b, required acks=%0d busy=0",
                     d_ack_seen, busy, base);
        end
        d_req = 1'b1;
        d_addr = 64'h308;
        exp_q.push_back({1'b1, 64'h77});
        tick();
        n_tests++;
        if (mem_addr_valid !== 1'b1 || mem_addr !== 64'h308) begin
            n_fail++;
            $display("FAIL post_reset_issue: valid=%b addr=%h, required 1 308", mem_addr_valid, mem_addr);
        end
        bus_respond(0, 64'h77);
        e = pop_exp();
        n_tests++;
        if ({i_ack, d_ack} !== {~e.is_d, e.is_d} || d_rdata !== e.data) begin
            n_fail++;
            $display("FAIL post_reset_ack: i/d ack=%b%b rdata=%h, required %b%b %h",
                     i_ack, d_ack, d_rdata, ~e.is_d, e.is_d, e.data);
        end
        d_req = 1'b0;
        tick();
    endtask

`ifdef UNIFIED_MEM_ARBITER_TIMEOUT_EN
    task automatic test_timeout();
        exp_t e;
        i_req = 1'b1;
        i_addr = 64'h500;
        exp_q.push_back({1'b0, {DW{1'b1}}});
        mem_din_ready = 1'b0;
        tick();
        repeat (7) tick();
        n_tests++;
        if (i_ack !== 1'b0 || mem_addr_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_early: ack=%b valid=%b at grant cycle 8, required 0 1", i_ack, mem_addr_valid);
        end
        tick();
        e = pop_exp();
        n_tests++;
        if ({i_ack, d_ack} !== {~e.is_d, e.is_d} || i_rdata !== e.data || err !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_ack: i/d ack=%b%b rdata=%h err=%b, required %b%b %h err=1",
                     i_ack, d_ack, i_rdata, err, ~e.is_d, e.is_d, e.data);
        end
        i_req = 1'b0;
        repeat (3) tick();
        n_tests++;
        if (err !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_sticky: err=%b busy=%b, required 1 0", err, busy);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_fetch();
        test_data_write();
        test_back_to_back();
        test_stall();
        test_reset_mid();
`ifdef UNIFIED_MEM_ARBITER_TIMEOUT_EN
        test_timeout();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
